// File: rtl/alu_pkg.sv
// Shared ALU op codes and the multi-cycle sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for the longer latency, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Holds MUL/DIV operands on the ALU for a fixed multicycle window, then captures HI/LO and flags.
// Latency: MUL_LAT (or DIV_LAT) edges from accepted start to capture, done the cycle after.
// Backpressure: busy stalls upstream; start/wr_hi/wr_lo are dropped whenever busy is high.
module muldiv_seq_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  fs,
  input  logic [31:0] s_in,
  input  logic [31:0] t_in,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] alu_S,
  output logic [31:0] alu_T,
  output logic [4:0]  alu_FS,
  input  logic [31:0] alu_y_hi,
  input  logic [31:0] alu_y_lo,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        n_flag,
  output logic        z_flag,
  output logic        dz
);

  localparam int            CW       = cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          div_zero;
  logic          capture;

  assign accept   = (state == ST_IDLE) && start && ((fs == FS_MUL) || (fs == FS_DIV));
  // Zero divisor is checked on the registered operand, so it spends one RUN cycle.
  assign div_zero = (alu_FS == FS_DIV) && (alu_T == 32'd0);
  assign capture  = (state == ST_RUN) && !div_zero && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (div_zero || (cnt == '0)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_S  <= 32'd0;
      alu_T  <= 32'd0;
      alu_FS <= 5'h00;
    end else if (accept) begin
      alu_S  <= s_in;
      alu_T  <= t_in;
      alu_FS <= fs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (fs == FS_DIV) ? DIV_LOAD : MUL_LOAD;
    end else if ((state == ST_RUN) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end else if (state != ST_RUN) begin
      cnt <= '0;
    end
  end

  // MTHI/MTLO land in IDLE; a start in the same cycle later overwrites them at capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (capture) begin
      hi <= alu_y_hi;
      lo <= alu_y_lo;
    end else if (state == ST_IDLE) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_flag <= 1'b0;
      z_flag <= 1'b0;
      dz     <= 1'b0;
    end else begin
      if (capture) begin
        n_flag <= alu_n;
        z_flag <= alu_z;
      end
      if (accept) begin
        dz <= 1'b0;
      end else if ((state == ST_RUN) && div_zero) begin
        dz <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl with a behavioural stand-in for ALU_32.
module tb_muldiv_seq_ctrl;

  localparam logic [4:0] F_MUL = 5'h1E;
  localparam logic [4:0] F_DIV = 5'h1F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  fs = 5'h00;
  logic [31:0] s_in = 32'd0;
  logic [31:0] t_in = 32'd0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] alu_S, alu_T;
  logic [4:0]  alu_FS;
  logic [31:0] alu_y_hi, alu_y_lo;
  logic        alu_n, alu_z;
  logic        busy, done, n_flag, z_flag, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        n;
    logic        z;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq_ctrl #(.MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .fs(fs), .s_in(s_in), .t_in(t_in),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .alu_S(alu_S), .alu_T(alu_T), .alu_FS(alu_FS),
    .alu_y_hi(alu_y_hi), .alu_y_lo(alu_y_lo), .alu_n(alu_n), .alu_z(alu_z),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .n_flag(n_flag), .z_flag(z_flag), .dz(dz)
  );

  // ALU_32 stand-in: signed multiply / signed divide (remainder on HI).
  logic signed [63:0] m_prod;
  logic signed [31:0] m_q, m_r;
  always_comb begin
    m_prod   = $signed(alu_S) * $signed(alu_T);
    m_q      = 32'sd0;
    m_r      = 32'sd0;
    if (alu_T != 32'd0) begin
      m_q = $signed(alu_S) / $signed(alu_T);
      m_r = $signed(alu_S) % $signed(alu_T);
    end
    alu_y_hi = 32'd0;
    alu_y_lo = 32'd0;
    alu_n    = 1'b0;
    alu_z    = 1'b0;
    if (alu_FS == F_MUL) begin
      alu_y_hi = m_prod[63:32];
      alu_y_lo = m_prod[31:0];
      alu_n    = m_prod[63];
      alu_z    = (m_prod == 64'sd0);
    end else if (alu_FS == F_DIV) begin
      alu_y_hi = m_r;
      alu_y_lo = m_q;
      alu_n    = m_q[31];
      alu_z    = (m_q == 32'sd0);
    end
  end

  task automatic launch(input logic [4:0] f, input logic [31:0] s, input logic [31:0] t,
                        input logic [31:0] eh, input logic [31:0] el, input logic en,
                        input logic ez, input logic edz, input int elat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; fs = f; s_in = s; t_in = t;
    @(posedge clk); #1;
    start = 1'b0;
    e.hi = eh; e.lo = el; e.n = en; e.z = ez; e.dz = edz; e.lat = elat; e.t0 = cyc;
    sb.push_back(e);
    checks++;
    if (busy !== 1'b1 || alu_FS !== f || alu_S !== s || alu_T !== t) begin
      errors++;
      $display("FAIL accept: busy=%b fs=%h S=%h T=%h required busy=1 fs=%h S=%h T=%h",
               busy, alu_FS, alu_S, alu_T, f, s, t);
    end
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 60 cycles", name);
      return;
    end
    lat = cyc - e.t0 + 1;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    end
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h required %h_%h", name, hi, lo, e.hi, e.lo);
    end
    checks++;
    if (n_flag !== e.n || z_flag !== e.z || dz !== e.dz) begin
      errors++;
      $display("FAIL %s flags: got n=%b z=%b dz=%b required n=%b z=%b dz=%b",
               name, n_flag, z_flag, dz, e.n, e.z, e.dz);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b busy=%b required done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 ||
        n_flag !== 1'b0 || z_flag !== 1'b0 || dz !== 1'b0 ||
        alu_S !== 32'd0 || alu_T !== 32'd0 || alu_FS !== 5'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h n=%b z=%b dz=%b S=%h T=%h FS=%h required all 0",
               busy, done, hi, lo, n_flag, z_flag, dz, alu_S, alu_T, alu_FS);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mul();
    launch(F_MUL, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0, 5);
    wait_done("mul");
  endtask

  task automatic test_div_zero();
    launch(F_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b1, 2);
    wait_done("div_zero");
  endtask

  task automatic test_div();
    launch(F_DIV, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0, 1'b0, 9);
    wait_done("div");
  endtask

  task automatic test_busy_ignored();
    launch(F_MUL, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    start = 1'b1; fs = F_MUL; s_in = 32'd2; t_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (alu_S !== 32'd5 || alu_T !== 32'd6) begin
      errors++;
      $display("FAIL busy_start: S=%h T=%h required S=5 T=6", alu_S, alu_T);
    end
    wait_done("busy_mul");
    @(negedge clk);
    start = 1'b1; fs = 5'h00; s_in = 32'd11; t_in = 32'd12;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL bad_fs cycle %0d: busy=%b done=%b required 0 0", i, busy, done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (alu_FS !== F_MUL || alu_S !== 32'd5 || lo !== 32'd30) begin
      errors++;
      $display("FAIL bad_fs hold: FS=%h S=%h lo=%h required FS=1e S=5 lo=1e", alu_FS, alu_S, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'd30) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h required hi=deadbeef lo=0000001e", hi, lo);
    end
    launch(F_MUL, 32'h10, 32'h10, 32'd0, 32'h100, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    checks++;
    if (lo !== 32'd30) begin
      errors++;
      $display("FAIL mtlo_busy: lo=%h required 0000001e", lo);
    end
    wait_done("mtlo_run");
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h required cafef00d both", hi, lo);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hAAAA_5555;
    start = 1'b1; fs = F_MUL; s_in = 32'd1; t_in = 32'd1;
    @(posedge clk); #1;
    wr_hi = 1'b0; start = 1'b0;
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd1; e.n = 1'b0; e.z = 1'b0; e.dz = 1'b0; e.lat = 5; e.t0 = cyc;
      sb.push_back(e);
    end
    checks++;
    if (hi !== 32'hAAAA_5555 || busy !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle write: hi=%h busy=%b required aaaa5555 1", hi, busy);
    end
    wait_done("same_cycle");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] s, t;
      logic signed [63:0] p;
      logic signed [31:0] q, r;
      s = (k == 2) ? 32'd0 : $urandom;
      if (k % 2 == 0) begin
        t = $urandom;
        p = $signed(s) * $signed(t);
        launch(F_MUL, s, t, p[63:32], p[31:0], p[63], p == 64'sd0, 1'b0, 5);
      end else begin
        t = $urandom_range(1, 1000);
        if ($urandom_range(0, 1) == 1) t = -t;
        q = $signed(s) / $signed(t);
        r = $signed(s) % $signed(t);
        launch(F_DIV, s, t, r, q, q[31], q == 32'sd0, 1'b0, 9);
      end
      wait_done("back_to_back");
    end
  endtask

  task automatic test_reset_mid_run();
    launch(F_MUL, 32'd4, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5);
    void'(sb.pop_front());
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || alu_FS !== 5'h00) begin
      errors++;
      $display("FAIL reset_run: busy=%b hi=%h lo=%h FS=%h required 0 0 0 0", busy, hi, lo, alu_FS);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_run after %0d: done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_zero();
    test_div();
    test_busy_ignored();
    test_mthi_mtlo();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
